// File: rtl/grant_bus_ctrl.sv
// grant_bus_ctrl: locks the arbiter's winning client as bus owner and streams
// its burst to the shared target over valid/ready, pulsing a per-client done.
module grant_bus_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [LEN_W-1:0]  len_0,
    input  logic [DATA_W-1:0] data_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [LEN_W-1:0]  len_1,
    input  logic [DATA_W-1:0] data_1,
    input  logic              tgt_ready,
    output logic              tgt_valid,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic [DATA_W-1:0] tgt_data,
    output logic              tgt_owner,
    output logic              data_ack_0,
    output logic              data_ack_1,
    output logic              done_0,
    output logic              done_1,
    output logic              busy,
    output logic              err_both
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t            state, state_n;
    logic [LEN_W-1:0]  beats_left, beats_left_n;
    logic [ADDR_W-1:0] addr_n;
    logic              valid_n, owner_n, done_0_n, done_1_n, busy_n, err_n, accept;
    assign accept     = tgt_valid & tgt_ready;
    assign tgt_data   = tgt_owner ? data_1 : data_0;
    assign data_ack_0 = accept & ~tgt_owner;
    assign data_ack_1 = accept & tgt_owner;
    always_comb begin
        state_n      = state;
        valid_n      = tgt_valid;
        addr_n       = tgt_addr;
        owner_n      = tgt_owner;
        beats_left_n = beats_left;
        busy_n       = busy;
        done_0_n     = 1'b0;
        done_1_n     = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: if (gnt_0 | gnt_1) begin
                // client 0 wins a simultaneous grant; the collision is flagged
                state_n      = XFER;
                valid_n      = 1'b1;
                busy_n       = 1'b1;
                owner_n      = ~gnt_0;
                addr_n       = gnt_0 ? addr_0 : addr_1;
                beats_left_n = gnt_0 ? len_0 : len_1;
                err_n        = gnt_0 & gnt_1;
            end
            XFER: if (accept) begin
                if (beats_left == '0) begin
                    state_n  = DONE;
                    valid_n  = 1'b0;
                    done_0_n = ~tgt_owner;
                    done_1_n = tgt_owner;
                end else begin
                    addr_n       = tgt_addr + 1'b1;
                    beats_left_n = beats_left - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tgt_valid  <= 1'b0;
            tgt_addr   <= '0;
            tgt_owner  <= 1'b0;
            beats_left <= '0;
            done_0     <= 1'b0;
            done_1     <= 1'b0;
            busy       <= 1'b0;
            err_both   <= 1'b0;
        end else begin
            state      <= state_n;
            tgt_valid  <= valid_n;
            tgt_addr   <= addr_n;
            tgt_owner  <= owner_n;
            beats_left <= beats_left_n;
            done_0     <= done_0_n;
            done_1     <= done_1_n;
            busy       <= busy_n;
            err_both   <= err_n;
        end
    end
endmodule

// File: tb/tb_grant_bus_ctrl.sv
// tb_grant_bus_ctrl: randomized burst scenarios checked against a beat-count
// model of the expected per-cycle trace.
module tb_grant_bus_ctrl;
    logic        clock = 1'b0, reset = 1'b1;
    logic        gnt_0 = 1'b0, gnt_1 = 1'b0, tgt_ready = 1'b0;
    logic [7:0]  addr_0 = '0, addr_1 = '0;
    logic [3:0]  len_0 = '0, len_1 = '0;
    logic [15:0] data_0 = '0, data_1 = '0;
    logic        tgt_valid, tgt_owner, data_ack_0, data_ack_1, done_0, done_1, busy, err_both;
    logic [7:0]  tgt_addr;
    logic [15:0] tgt_data;
    int checks = 0, errors = 0;
    typedef struct packed {
        logic v, own, ack0, ack1, dn0, dn1, bsy, err;
        logic [7:0]  addr;
        logic [15:0] data;
    } rec_t;
    rec_t log_q [64];
    bit   rdy [64];
    int   acc0, acc1;

    grant_bus_ctrl #(.ADDR_W(8), .DATA_W(16), .LEN_W(4)) dut (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .addr_0(addr_0), .len_0(len_0), .data_0(data_0),
        .addr_1(addr_1), .len_1(len_1), .data_1(data_1),
        .tgt_ready(tgt_ready), .tgt_valid(tgt_valid), .tgt_addr(tgt_addr),
        .tgt_data(tgt_data), .tgt_owner(tgt_owner), .data_ack_0(data_ack_0),
        .data_ack_1(data_ack_1), .done_0(done_0), .done_1(done_1),
        .busy(busy), .err_both(err_both)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Clients present base+consumed_count and advance only when acked.
    task automatic run(input int n, input bit toggle, input int stop_toggle);
        for (int k = 0; k < n; k++) begin
            tgt_ready = rdy[k];
            data_0 = 16'h1000 + 16'(acc0);
            data_1 = 16'h2000 + 16'(acc1);
            if (toggle) gnt_1 = (k < stop_toggle) ? 1'($urandom) : 1'b0;
            #1;
            log_q[k].v = tgt_valid;   log_q[k].own = tgt_owner;
            log_q[k].ack0 = data_ack_0; log_q[k].ack1 = data_ack_1;
            log_q[k].dn0 = done_0;    log_q[k].dn1 = done_1;
            log_q[k].bsy = busy;      log_q[k].err = err_both;
            log_q[k].addr = tgt_addr; log_q[k].data = tgt_data;
            step();
            if (log_q[k].ack0) acc0++;
            if (log_q[k].ack1) acc1++;
        end
        tgt_ready = 1'b0;
        gnt_1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; gnt_0 = 1'b1; gnt_1 = 1'b1; tgt_ready = 1'b1;
        step(); step();
        checks++;
        if ({tgt_valid, tgt_addr, tgt_owner, done_0, done_1, busy, err_both, data_ack_0, data_ack_1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b a=%h o=%b d=%b%b b=%b e=%b ack=%b%b exp all 0",
                     tgt_valid, tgt_addr, tgt_owner, done_0, done_1, busy, err_both, data_ack_0, data_ack_1);
        end
        gnt_0 = 1'b0; gnt_1 = 1'b0; tgt_ready = 1'b0; reset = 1'b0;
        step();
        checks++;
        if ({tgt_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got v=%b b=%b exp 00", tgt_valid, busy);
        end
    endtask

    // mode 0: ready always high, 1: 0,0,1,0,1 then high, 2: random
    task automatic test_burst(input string name, input bit c, input bit both, input bit toggle,
                              input logic [7:0] a, input logic [3:0] l, input int mode);
        int at [64];
        int acc = 0, done_k = -1;
        bit eo, ev;
        bit [4:0] pat = 5'b10100;
        logic [15:0] base;
        for (int k = 0; k < 64; k++)
            rdy[k] = (mode == 0 || k >= 40) ? 1'b1 : (mode == 1) ? (k < 5 ? pat[k] : 1'b1) : 1'($urandom);
        for (int k = 0; k < 64; k++) begin
            at[k] = acc;
            if (acc <= int'(l) && rdy[k]) begin
                acc++;
                if (acc == int'(l) + 1) done_k = k + 1;
            end
        end
        eo = both ? 1'b0 : c;
        base = eo ? 16'h2000 : 16'h1000;
        acc0 = 0; acc1 = 0;
        addr_0 = (c == 1'b0 || both) ? a : 8'($urandom);
        len_0  = (c == 1'b0 || both) ? l : 4'($urandom);
        addr_1 = (c == 1'b1 && !both) ? a : 8'($urandom);
        len_1  = (c == 1'b1 && !both) ? l : 4'($urandom);
        gnt_0 = !c || both; gnt_1 = c || both;
        step();
        gnt_0 = 1'b0; gnt_1 = 1'b0;
        addr_0 = 8'($urandom); len_0 = 4'($urandom); addr_1 = 8'($urandom); len_1 = 4'($urandom);
        run(done_k + 2, toggle, done_k);
        for (int k = 0; k <= done_k + 1; k++) begin
            ev = k < done_k;
            checks++;
            if (log_q[k].v !== ev) begin
                errors++;
                $display("FAIL %s valid k=%0d got %b exp %b", name, k, log_q[k].v, ev);
            end
            if (ev) begin
                checks++;
                if (log_q[k].addr !== 8'(int'(a) + at[k]) || log_q[k].data !== base + 16'(at[k])) begin
                    errors++;
                    $display("FAIL %s beat k=%0d got a=%h d=%h exp a=%h d=%h", name, k,
                             log_q[k].addr, log_q[k].data, 8'(int'(a) + at[k]), base + 16'(at[k]));
                end
            end
            if (k <= done_k) begin
                checks++;
                if (log_q[k].own !== eo) begin
                    errors++;
                    $display("FAIL %s owner k=%0d got %b exp %b", name, k, log_q[k].own, eo);
                end
            end
            checks++;
            if (log_q[k].ack0 !== (ev && rdy[k] && !eo) || log_q[k].ack1 !== (ev && rdy[k] && eo)) begin
                errors++;
                $display("FAIL %s ack k=%0d got %b%b exp %b%b", name, k, log_q[k].ack0, log_q[k].ack1,
                         ev && rdy[k] && !eo, ev && rdy[k] && eo);
            end
            checks++;
            if (log_q[k].dn0 !== (k == done_k && !eo) || log_q[k].dn1 !== (k == done_k && eo)) begin
                errors++;
                $display("FAIL %s done k=%0d got %b%b exp %b%b", name, k, log_q[k].dn0, log_q[k].dn1,
                         k == done_k && !eo, k == done_k && eo);
            end
            checks++;
            if (log_q[k].bsy !== (k <= done_k) || log_q[k].err !== (both && k == 0)) begin
                errors++;
                $display("FAIL %s busy_err k=%0d got b=%b e=%b exp b=%b e=%b", name, k,
                         log_q[k].bsy, log_q[k].err, k <= done_k, both && k == 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        acc0 = 0; acc1 = 0;
        addr_0 = 8'h40; len_0 = 4'd3; gnt_0 = 1'b1;
        step();
        gnt_0 = 1'b0;
        rdy[0] = 1'b1;
        run(1, 1'b0, 0);
        tgt_ready = 1'b1; reset = 1'b1;
        #1;
        checks++;
        if (tgt_valid !== 1'b1 || tgt_addr !== 8'h41) begin
            errors++;
            $display("FAIL reset_mid_beat2 got v=%b a=%h exp v=1 a=41", tgt_valid, tgt_addr);
        end
        step();
        reset = 1'b0; tgt_ready = 1'b0;
        checks++;
        if ({tgt_valid, tgt_addr, tgt_owner, done_0, done_1, busy, err_both} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_clear got v=%b a=%h o=%b d=%b%b b=%b e=%b exp all 0",
                     tgt_valid, tgt_addr, tgt_owner, done_0, done_1, busy, err_both);
        end
        step();
        checks++;
        if ({tgt_valid, done_0, done_1, busy} !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_nodone got v=%b d=%b%b b=%b exp 0", tgt_valid, done_0, done_1, busy);
        end
    endtask

    initial begin
        test_reset();
        test_burst("single", 1'b0, 1'b0, 1'b0, 8'h10, 4'd3, 0);
        test_burst("one_beat", 1'b0, 1'b0, 1'b0, 8'h77, 4'd0, 0);
        test_burst("both", 1'b0, 1'b1, 1'b0, 8'($urandom), 4'($urandom), 0);
        test_burst("client1_after_both", 1'b1, 1'b0, 1'b0, 8'($urandom), 4'($urandom), 0);
        test_burst("wrap", 1'b1, 1'b0, 1'b0, 8'hFE, 4'd2, 0);
        test_burst("stall", 1'b0, 1'b0, 1'b0, 8'h33, 4'd1, 1);
        test_reset_mid();
        test_burst("after_reset_mid", 1'b1, 1'b0, 1'b0, 8'h90, 4'd3, 0);
        test_burst("gnt_toggle", 1'b0, 1'b0, 1'b1, 8'h80, 4'd5, 2);
        test_burst("max_len", 1'b1, 1'b0, 1'b0, 8'hF8, 4'd15, 2);
        for (int i = 0; i < 8; i++)
            test_burst("random", 1'($urandom), 1'b0, 1'b0, 8'($urandom), 4'($urandom), 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
